// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state types and counter sizing helper for the UART transceiver
// Contents:
//   tx_state_t  TX engine states (IDLE, START, DATA, PARITY, STOP)
//   rx_state_t  RX engine states (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE)
//   cnt_width() bits needed to count 0..n-1 (never less than 1)
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - UART receive engine: 2-flop synchroniser, bit timer and RX FSM
// Optional feature macro: UART_PARITY_EN (adds a parity bit after the data bits)
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   rx             asynchronous serial input pin
//   loopback_q     1 = take loop_serial instead of the synchronised pin
//   loop_serial    internal TX serial stream (already in the clk domain)
//   rx_data        last correctly framed word
//   rx_valid       one-cycle pulse, rx_data updated
//   rx_frame_err   one-cycle pulse, stop bit sampled low
//   rx_parity_err  one-cycle pulse, parity mismatch (0 without UART_PARITY_EN)
//   rx_idle        FSM is in IDLE (used to gate loopback changes)
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 loopback_q,
  input  logic                 loop_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_idle
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(DATA_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic [1:0]           sync;
  logic                 rx_line;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_done;
  logic                 half_done;

`ifdef UART_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic par_err;
  logic parity_err_q;
  assign rx_parity_err = parity_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

  // Loopback traffic is generated in this clock domain, so it skips the synchroniser.
  assign rx_line   = loopback_q ? loop_serial : sync[1];
  assign bit_done  = (cnt == BIT_END);
  assign half_done = (cnt == HALF_BIT);
  assign rx_idle   = (state == RX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  // After the start-bit check at half a bit, the timer is restarted so every
  // later bit_done lands in the middle of the next bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_err      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_line) begin
            state <= RX_START;
          end
        end

        RX_START: begin
          if (half_done) begin
            cnt   <= '0;
            // High at mid start bit: treat as a glitch and drop it silently.
            state <= rx_line ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RX_DATA: begin
          if (bit_done) begin
            cnt   <= '0;
            shreg <= {rx_line, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
`ifdef UART_PARITY_EN
              state   <= RX_PARITY;
`else
              state   <= RX_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (bit_done) begin
            cnt     <= '0;
            par_err <= (rx_line != ((^shreg) ^ PAR_ODD));
            state   <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif

        RX_STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (rx_line) begin
              state <= RX_IDLE;
`ifdef UART_PARITY_EN
              if (par_err) begin
                parity_err_q <= 1'b1;
              end else begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end
`else
              rx_data  <= shreg;
              rx_valid <= 1'b1;
`endif
            end else begin
              rx_frame_err <= 1'b1;
`ifdef UART_PARITY_EN
              parity_err_q <= par_err;
`endif
              state        <= RX_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RX_WAIT_IDLE: begin
          // A low line here is the tail of a broken frame, not a new start bit.
          if (rx_line) begin
            state <= RX_IDLE;
          end
        end

        default: begin
          state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - full-duplex parametrised UART: inline TX engine, RX engine, loopback
// Optional feature macro: UART_PARITY_EN (parity bit after the data bits, even or odd by PARITY_ODD)
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   tx_data        word to transmit, taken on tx_valid && tx_ready
//   tx_valid       tx_data valid; must be held until accepted
//   tx_ready       TX engine idle and able to accept
//   tx             serial output pin, idle high, held high in loopback
//   rx             serial input pin (asynchronous)
//   rx_data        last correctly framed word
//   rx_valid       one-cycle pulse, rx_data updated
//   rx_frame_err   one-cycle pulse, stop bit sampled low
//   rx_parity_err  one-cycle pulse, parity mismatch
//   loopback       request internal TX -> RX routing (applied only when both engines idle)
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  input  logic                 loopback
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(DATA_BITS);
  localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_stop_idx;
  logic                 tx_serial;
  logic                 tx_ready_q;
  logic                 tx_bit_done;
  logic                 loopback_q;
  logic                 rx_idle;

`ifdef UART_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic tx_par;
`endif

  assign tx_bit_done = (tx_cnt == BIT_END);
  assign tx_ready    = tx_ready_q;
  assign tx          = loopback_q ? 1'b1 : tx_serial;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_bit_idx  <= '0;
      tx_shift    <= '0;
      tx_stop_idx <= 1'b0;
      tx_serial   <= 1'b1;
      tx_ready_q  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par      <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_serial <= 1'b1;
          tx_cnt    <= '0;
          if (tx_valid && tx_ready_q) begin
            tx_shift    <= tx_data;
            tx_ready_q  <= 1'b0;
            tx_serial   <= 1'b0;
            tx_bit_idx  <= '0;
            tx_stop_idx <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par      <= (^tx_data) ^ PAR_ODD;
`endif
            tx_state    <= TX_START;
          end
        end

        // tx_shift is consumed from bit 0; each bit boundary presents the
        // next LSB and shifts the rest down.
        TX_START: begin
          if (tx_bit_done) begin
            tx_cnt    <= '0;
            tx_serial <= tx_shift[0];
            tx_shift  <= tx_shift >> 1;
            tx_state  <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end

        TX_DATA: begin
          if (tx_bit_done) begin
            tx_cnt <= '0;
            if (tx_bit_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
              tx_serial <= tx_par;
              tx_state  <= TX_PARITY;
`else
              tx_serial <= 1'b1;
              tx_state  <= TX_STOP;
`endif
            end else begin
              tx_serial  <= tx_shift[0];
              tx_shift   <= tx_shift >> 1;
              tx_bit_idx <= tx_bit_idx + BW'(1);
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end

`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_bit_done) begin
            tx_cnt    <= '0;
            tx_serial <= 1'b1;
            tx_state  <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
`endif

        TX_STOP: begin
          if (tx_bit_done) begin
            tx_cnt <= '0;
            if (tx_stop_idx == LAST_STOP) begin
              tx_ready_q <= 1'b1;
              tx_state   <= TX_IDLE;
            end else begin
              tx_stop_idx <= 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end

        default: begin
          tx_state   <= TX_IDLE;
          tx_serial  <= 1'b1;
          tx_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Switching the RX source mid-frame would corrupt both directions, so the
  // request is only taken while neither engine is busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      loopback_q <= 1'b0;
    end else if ((tx_state == TX_IDLE) && rx_idle) begin
      loopback_q <= loopback;
    end
  end

  uart_rx_engine #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS),
    .PARITY_ODD   (PARITY_ODD)
  ) u_rx (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .loopback_q    (loopback_q),
    .loop_serial   (tx_serial),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_idle       (rx_idle)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - self-checking bench for uart_transceiver with a frame-level reference model
`timescale 1ns/1ps
module tb_uart_transceiver;

  localparam int C  = 16;
  localparam int DB = 8;
  localparam int SB = 1;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_BITS = 1 + DB + PB + SB;
  localparam int FRAME_CYC  = FRAME_BITS * C;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       loopback;

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_q[$];
  int fe_cnt = 0;
  int pe_cnt = 0;
  int tx_low_cnt = 0;

  always #5 clk = ~clk;

  uart_transceiver #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (DB),
    .STOP_BITS    (SB),
    .PARITY_ODD   (0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx            (tx),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .loopback      (loopback)
  );

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_q.push_back(rx_data);
    if (rx_frame_err === 1'b1) fe_cnt++;
    if (rx_parity_err === 1'b1) pe_cnt++;
    if (tx !== 1'b1) tx_low_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: serial line level of frame bit idx for word d
  // (0 start, 1..DB data LSB first, then even parity if enabled, then stop).
  function automatic logic exp_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return d[idx-1];
    if (PB == 1 && idx == DB + 1) return ^d;
    return 1'b1;
  endfunction

  task automatic tx_send(input logic [7:0] d);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL tx_send_timeout: tx_ready=%b want 1", tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Called in the first cycle after acceptance; ends in the first ready cycle.
  task automatic check_tx_frame(input logic [7:0] d, input string name);
    int   wave_bad;
    int   first;
    int   rdy_low;
    logic e;
    logic fa;
    logic fe;
    wave_bad = 0; first = -1; rdy_low = 0; fa = 1'b0; fe = 1'b0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      e = exp_bit(d, i / C);
      if (tx !== e) begin
        if (wave_bad == 0) begin first = i; fa = tx; fe = e; end
        wave_bad++;
      end
      if (tx_ready === 1'b0) rdy_low++;
      @(negedge clk);
    end
    total++;
    if (wave_bad != 0) begin
      bad++;
      $display("FAIL %s_wave: %0d bad cycles, first at %0d tx=%b want %b", name, wave_bad, first, fa, fe);
    end
    total++;
    if (rdy_low !== FRAME_CYC) begin
      bad++;
      $display("FAIL %s_ready_low: got %0d cycles want %0d", name, rdy_low, FRAME_CYC);
    end
    total++;
    if (tx_ready !== 1'b1 || tx !== 1'b1) begin
      bad++;
      $display("FAIL %s_end: tx_ready=%b tx=%b want 1 1", name, tx_ready, tx);
    end
  endtask

  task automatic rx_drive(input logic [7:0] d, input logic stop_val, input logic flip_par);
    logic b;
    for (int idx = 0; idx < FRAME_BITS; idx++) begin
      b = exp_bit(d, idx);
      if (PB == 1 && idx == DB + 1 && flip_par) b = ~b;
      if (idx >= 1 + DB + PB) b = stop_val;
      rx = b;
      repeat (C) @(negedge clk);
    end
    if (stop_val) rx = 1'b1;
  endtask

  task automatic wait_rx(input int target);
    int n;
    n = 0;
    while (rx_q.size() < target && n < 4 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx = 1'b1; loopback = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", rx_frame_err); end
    total++; if (rx_parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err: got %b want 0", rx_parity_err); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_frame();
    tx_send(8'hA5);
    check_tx_frame(8'hA5, "tx_a5");
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      tx_send(d);
      check_tx_frame(d, "tx_b2b");
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [7:0] sent[$];
    int base;
    int low_base;
    int fe_base;
    sent = '{8'h3C, 8'hC3};
    for (int i = 0; i < 3; i++) sent.push_back(8'($urandom));
    loopback = 1'b1;
    repeat (4) @(negedge clk);
    base = rx_q.size();
    low_base = tx_low_cnt;
    fe_base = fe_cnt;
    foreach (sent[i]) tx_send(sent[i]);
    wait_rx(base + sent.size());
    total++;
    if (rx_q.size() - base !== sent.size()) begin
      bad++;
      $display("FAIL loop_count: got %0d words want %0d", rx_q.size() - base, sent.size());
    end
    foreach (sent[i]) begin
      if (base + i < rx_q.size()) begin
        total++;
        if (rx_q[base + i] !== sent[i]) begin
          bad++;
          $display("FAIL loop_word%0d: got %h want %h", i, rx_q[base + i], sent[i]);
        end
      end
    end
    total++;
    if (tx_low_cnt - low_base !== 0) begin
      bad++;
      $display("FAIL loop_tx_pin: tx low for %0d cycles want 0", tx_low_cnt - low_base);
    end
    total++;
    if (fe_cnt - fe_base !== 0) begin
      bad++;
      $display("FAIL loop_frame_err: got %0d pulses want 0", fe_cnt - fe_base);
    end
    repeat (2 * C) @(negedge clk);
    loopback = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_glitch();
    int base;
    int fe_base;
    logic [7:0] d;
    base = rx_q.size();
    fe_base = fe_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * C) @(negedge clk);
    total++;
    if (rx_q.size() - base !== 0) begin bad++; $display("FAIL glitch_valid: got %0d words want 0", rx_q.size() - base); end
    total++;
    if (fe_cnt - fe_base !== 0) begin bad++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt - fe_base); end
    d = 8'($urandom);
    rx_drive(d, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (rx_q.size() - base !== 1 || rx_q[rx_q.size() - 1] !== d) begin
      bad++;
      $display("FAIL glitch_recover: got %0d words last %h want 1 word %h", rx_q.size() - base, rx_data, d);
    end
  endtask

  task automatic test_frame_err();
    int base;
    int fe_base;
    int pe_base;
    logic [7:0] d;
    rx_drive(8'h5A, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (rx_data !== 8'h5A) begin bad++; $display("FAIL ferr_prior: rx_data=%h want 5a", rx_data); end
    base = rx_q.size();
    fe_base = fe_cnt;
    pe_base = pe_cnt;
    rx_drive(8'h55, 1'b0, 1'b0);
    repeat (2 * C) @(negedge clk);
    total++;
    if (fe_cnt - fe_base !== 1) begin bad++; $display("FAIL ferr_pulse: got %0d pulses want 1", fe_cnt - fe_base); end
    total++;
    if (rx_q.size() - base !== 0) begin bad++; $display("FAIL ferr_no_valid: got %0d words want 0", rx_q.size() - base); end
    total++;
    if (rx_data !== 8'h5A) begin bad++; $display("FAIL ferr_rx_data: got %h want 5a", rx_data); end
    total++;
    if (pe_cnt - pe_base !== 0) begin bad++; $display("FAIL ferr_parity: got %0d pulses want 0", pe_cnt - pe_base); end
    rx = 1'b1;
    repeat (C) @(negedge clk);
    d = 8'($urandom);
    rx_drive(d, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (rx_q.size() - base !== 1 || rx_data !== d) begin
      bad++;
      $display("FAIL ferr_recover: got %0d words rx_data %h want 1 word %h", rx_q.size() - base, rx_data, d);
    end
  endtask

  task automatic test_rx_random();
    logic [7:0] sent[$];
    int base;
    base = rx_q.size();
    for (int i = 0; i < 4; i++) begin
      sent.push_back(8'($urandom));
      rx_drive(sent[i], 1'b1, 1'b0);
      repeat ($urandom_range(0, C)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    total++;
    if (rx_q.size() - base !== 4) begin bad++; $display("FAIL rxr_count: got %0d want 4", rx_q.size() - base); end
    foreach (sent[i]) begin
      if (base + i < rx_q.size()) begin
        total++;
        if (rx_q[base + i] !== sent[i]) begin
          bad++;
          $display("FAIL rxr_word%0d: got %h want %h", i, rx_q[base + i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = rx_q.size();
    tx_send(8'hFF);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", tx_ready); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_rx_data: got %h want 00", rx_data); end
    tx_send(8'h12);
    check_tx_frame(8'h12, "rstmid_12");
    total++;
    if (rx_q.size() - base !== 0) begin bad++; $display("FAIL rstmid_no_rx: got %0d words want 0", rx_q.size() - base); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    int base;
    int pe_base;
    int fe_base;
    int n;
    tx_send(8'h07);
    repeat (C * (1 + DB) + C / 2) @(negedge clk);
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL par_tx_bit: got %b want 1", tx); end
    n = 0;
    while (tx_ready !== 1'b1 && n < FRAME_CYC) begin @(negedge clk); n++; end
    base = rx_q.size();
    pe_base = pe_cnt;
    fe_base = fe_cnt;
    rx_drive(8'h3E, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (pe_cnt - pe_base !== 1) begin bad++; $display("FAIL par_err_pulse: got %0d want 1", pe_cnt - pe_base); end
    total++;
    if (rx_q.size() - base !== 0) begin bad++; $display("FAIL par_no_valid: got %0d words want 0", rx_q.size() - base); end
    rx_drive(8'hC1, 1'b0, 1'b1);
    repeat (C) @(negedge clk);
    rx = 1'b1;
    repeat (C) @(negedge clk);
    total++;
    if (pe_cnt - pe_base !== 2 || fe_cnt - fe_base !== 1) begin
      bad++;
      $display("FAIL par_both: parity pulses %0d frame pulses %0d want 2 1", pe_cnt - pe_base, fe_cnt - fe_base);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_loopback();
    test_glitch();
    test_frame_err();
    test_rx_random();
    test_reset_mid();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
